// File: rtl/bit_stuffer.sv
// bit_stuffer: passes serial bits through, inserting a 0 after RUN_LEN consecutive 1s and stalling upstream for that cycle
module bit_stuffer #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_eop,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_eop,
  output logic out_stuffed
);
  typedef enum logic [1:0] {IDLE, PASS, STUFF} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic stuff_eop, acc, trig;
  assign in_ready = ~rst & (state != STUFF);
  assign acc = in_valid & in_ready;
  assign cnt_inc = cnt + 1'b1;
  assign trig = in_bit & (cnt_inc == CNT_W'(RUN_LEN));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      stuff_eop <= 1'b0;
      out_bit <= 1'b0;
      out_valid <= 1'b0;
      out_eop <= 1'b0;
      out_stuffed <= 1'b0;
    end else if (state == STUFF) begin
      state <= stuff_eop ? IDLE : PASS;
      out_bit <= 1'b0;
      out_valid <= 1'b1;
      out_eop <= stuff_eop;
      out_stuffed <= 1'b1;
    end else if (acc) begin
      state <= trig ? STUFF : in_eop ? IDLE : PASS;
      cnt <= (in_bit & ~trig & ~in_eop) ? cnt_inc : '0;
      stuff_eop <= in_eop;
      out_bit <= in_bit;
      out_valid <= 1'b1;
      out_eop <= in_eop & ~trig;
      out_stuffed <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_eop <= 1'b0;
      out_stuffed <= 1'b0;
    end
endmodule

// File: tb/tb_bit_stuffer.sv
// tb_bit_stuffer: randomized and directed scoreboard bench for bit_stuffer
module tb_bit_stuffer;
  localparam int RUN_LEN = 6;
  logic clk = 1'b0, rst = 1'b1, in_bit = 1'b0, in_valid = 1'b0, in_eop = 1'b0;
  logic in_ready, out_bit, out_valid, out_eop, out_stuffed;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  logic mon_en = 1'b0;
  int checks = 0, passes = 0, n_out = 0, run = 0, n0;
  bit stall_exp = 1'b0;
  bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_eop(in_eop),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .out_eop(out_eop),
    .out_stuffed(out_stuffed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", {out_bit, out_eop, out_stuffed}, 3'bxxx);
        else begin
          mon_e = exp_q.pop_front();
          chk("out_bit_eop_stuffed", {out_bit, out_eop, out_stuffed}, mon_e);
          n_out++;
        end
      end else chk("idle_flags", {out_eop, out_stuffed}, 2'b00);
    end
  task automatic send_bit(input bit b, input bit e);
    bit t;
    int waits;
    t = b && (run + 1 == RUN_LEN);
    exp_q.push_back({b, e && !t, 1'b0});
    if (t) exp_q.push_back({1'b0, e, 1'b1});
    run = (b && !t && !e) ? run + 1 : 0;
    in_bit = b;
    in_eop = e;
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 4) begin
      @(negedge clk);
      waits++;
    end
    chk("stall_cycles", waits, stall_exp);
    @(negedge clk);
    in_valid = 1'b0;
    stall_exp = t;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_bit = 1'($urandom);
      in_eop = 1'($urandom);
      @(negedge clk);
      stall_exp = 1'b0;
    end
  endtask
  task automatic send_ones(input int n, input bit eop_last);
    for (int i = 0; i < n; i++) send_bit(1'b1, eop_last && i == n - 1);
  endtask
  task automatic drain(input string name, input int exp_n);
    idle(3);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_count"}, n_out - n0, exp_n);
    n0 = n_out;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) begin
      in_valid = 1'($urandom);
      in_bit = 1'($urandom);
      in_eop = 1'($urandom);
      chk("rst_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("rst_outputs", {out_valid, out_eop, out_stuffed}, 3'b000);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1'b1);
    mon_en = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 7);
    drain("ff_byte", 9);
    send_bit(1'b0, 1'b0);
    send_ones(6, 1'b1);
    drain("eop_on_trigger", 8);
    chk("idle_ready", in_ready, 1'b1);
    send_ones(5, 1'b0);
    send_bit(1'b0, 1'b0);
    send_ones(6, 1'b1);
    drain("zero_clears_run", 13);
    send_ones(3, 1'b0);
    idle(4);
    send_ones(3, 1'b1);
    drain("gap_retains_run", 7);
    send_ones(6, 1'b0);
    #1 rst = 1'b1;
    void'(exp_q.pop_back());
    chk("rst_ready_in_stuff", in_ready, 1'b0);
    @(negedge clk);
    chk("rst_kills_stuff", exp_q.size(), 0);
    rst = 1'b0;
    run = 0;
    stall_exp = 1'b0;
    #1 chk("ready_after_mid_rst", in_ready, 1'b1);
    n0 = n_out;
    send_ones(5, 1'b1);
    drain("after_mid_rst", 5);
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        send_bit(($urandom_range(0, 4) != 0), i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("random_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bit_stuffer.md
Name: bit_stuffer

Overview:
- Serial bit-stuffing stage directly downstream of the PISO shift register.
- Consumes one serial bit per cycle from the PISO output and passes it through.
- After RUN_LEN consecutive 1s it inserts a single 0, stalling the upstream shifter for that one cycle via in_ready, which drives the PISO enable.
- Output feeds the line encoder; packets are delimited by an end-of-packet flag carried alongside the last bit.

Parameters:
RUN_LEN, 6, number of consecutive 1s that triggers insertion of one stuffed 0
CNT_W, 3, width of the ones-run counter; must satisfy 2^CNT_W > RUN_LEN

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset; synchronous, active-high
in_bit  input  1  serial data bit from the upstream shifter
in_valid  input  1  in_bit is meaningful this cycle
in_eop  input  1  in_bit is the last bit of the packet; qualified by in_valid
in_ready  output  1  bit accepted this cycle when in_valid & in_ready; combinational from state
out_bit  output  1  serial output bit, registered
out_valid  output  1  out_bit is meaningful this cycle, registered
out_eop  output  1  out_bit is the final bit of the packet, including any trailing stuffed bit
out_stuffed  output  1  out_bit is an inserted stuff 0 (debug and verification aid)

Behaviour:
- Reset (rst high at a clock edge): next cycle out_bit=0, out_valid=0, out_eop=0, out_stuffed=0, state=IDLE, run count=0. in_ready=0 while rst is high. Reset overrides every other event, including mid-STUFF and mid-packet.
- States:
  - IDLE: no packet open.
  - PASS: packet open.
  - STUFF: one cycle emitting the inserted 0.
- in_ready=1 in IDLE and PASS; in_ready=0 in STUFF.
- Accept = in_valid & in_ready. When in_ready=0, in_valid and in_bit are ignored; upstream must hold its bit, and it is accepted on the next ready cycle.
- Latency: an accepted bit appears on out_bit with out_valid=1 exactly one cycle later.
- Any cycle without an accept and not in STUFF: out_valid=0, out_eop=0, out_stuffed=0 next cycle. out_bit holds its last value.
- Run counter, on accept:
  - in_bit=1: count = count+1.
  - in_bit=0: count = 0.
  - If the incremented count equals RUN_LEN: next state STUFF, count cleared to 0.
- STUFF cycle: the registered outputs for this cycle are out_bit=0, out_valid=1, out_stuffed=1. Next state is PASS, or IDLE if the bit that triggered the stuff carried in_eop.
- EOP on a non-triggering accepted bit: that bit is output with out_eop=1; count cleared; next state IDLE.
- EOP on the bit that triggers a stuff: the triggering bit is output with out_eop=0; the stuffed 0 that follows carries out_eop=1.
- Gaps inside a packet (in_valid low while in PASS): count is retained; the run continues across the gap.
- Count is always cleared at a packet boundary, so runs never span packets.
- IDLE→PASS on accepting a bit without in_eop. A single-bit packet (accept with in_eop from IDLE) stays in IDLE.
- Maximum output rate: RUN_LEN+1 output bits per RUN_LEN input 1s. No downstream backpressure; downstream always consumes.

Test Plan:
1. Reset: hold rst for 2 cycles during random in_valid traffic → out_valid=0, out_eop=0, out_stuffed=0 throughout; in_ready=1 on the first cycle after rst drops.
2. Contiguous 8'hFF sent LSB-first, in_eop on bit 7 → 9 output bits 1,1,1,1,1,1,0,1,1. out_stuffed=1 only on the 7th output; in_ready=0 for exactly the one cycle after the 6th accept; out_eop on the 9th output.
3. Packet 0,1,1,1,1,1,1 with in_eop on the last 1 → output 0,1,1,1,1,1,1,0. The stuffed 0 has out_eop=1 and out_stuffed=1; the final 1 has out_eop=0; state returns to IDLE.
4. Stream 1×5, 0, 1×6 → no stuff after the first five 1s (counter cleared by the 0); exactly one stuffed 0 after the 12th input bit; 13 valid outputs total.
5. Gap retention: three 1s, in_valid low for 4 cycles, three more 1s → stuffed 0 inserted after the 6th 1; out_valid=0 during the gap.
6. Reset mid-operation: assert rst on the cycle the FSM enters STUFF → no stuffed bit emitted, outputs zero; after release, a following 1×5 with eop produces no stuff.
